// File: rtl/ram_pkg.sv
// Shared types for the dual-port data RAM controller.
package ram_pkg;

  typedef enum logic {RAM_CLEAR, RAM_READY} ram_state_t;

endpackage

// File: rtl/dual_port_ram_ctrl_if.sv
// Bus bundle for the dual-port RAM: port A read/write, port B read-only, clear control.
interface dual_port_ram_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              a_cs;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_rdata;
  logic              a_rvalid;
  logic              b_cs;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_rdata;
  logic              b_rvalid;
  logic              clr_req;
  logic              ready;

  modport master (
    output a_cs, a_we, a_addr, a_wdata, b_cs, b_addr, clr_req,
    input  a_rdata, a_rvalid, b_rdata, b_rvalid, ready
  );

  modport slave (
    input  a_cs, a_we, a_addr, a_wdata, b_cs, b_addr, clr_req,
    output a_rdata, a_rvalid, b_rdata, b_rvalid, ready
  );
endinterface

// File: rtl/ram_array.sv
// Storage array: one write port, two enabled registered read ports, no reset (block-RAM friendly).
module ram_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              a_re_i,
  input  logic [ADDR_W-1:0] a_raddr_i,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_re_i,
  input  logic [ADDR_W-1:0] b_raddr_i,
  output logic [DATA_W-1:0] b_rdata_o
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Reads sample the pre-write word, giving read-before-write on collisions.
  always_ff @(posedge clk) begin
    if (we_i)   mem[waddr_i] <= wdata_i;
    if (a_re_i) a_rdata_o    <= mem[a_raddr_i];
    if (b_re_i) b_rdata_o    <= mem[b_raddr_i];
  end
endmodule

// File: rtl/dual_port_ram_ctrl.sv
// Dual-port data RAM controller: clear FSM, write-port mux (clear vs port A), read strobes.
module dual_port_ram_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dual_port_ram_ctrl_if.slave  bus
);
  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              a_rvalid_q, b_rvalid_q;
  logic              a_seen_q, b_seen_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              a_re, b_re;
  logic [DATA_W-1:0] arr_a_rdata, arr_b_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_READY;
      cnt_q      <= '0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_seen_q   <= 1'b0;
      b_seen_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_rvalid_q <= a_re;
      b_rvalid_q <= b_re;
      if (a_re) a_seen_q <= 1'b1;
      if (b_re) b_seen_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = bus.a_addr;
    mem_wdata = bus.a_wdata;
    a_re      = 1'b0;
    b_re      = 1'b0;
    if (state_q == RAM_CLEAR) begin
      // One word zeroed per cycle; ports are ignored until the sweep completes.
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
      cnt_d     = cnt_q + 1'b1;
      if (cnt_q == '1) state_d = RAM_READY;
    end else begin
      mem_we = bus.a_cs & bus.a_we;
      a_re   = bus.a_cs & ~bus.a_we;
      b_re   = bus.b_cs;
      if (bus.clr_req) begin
        state_d = RAM_CLEAR;
        cnt_d   = '0;
      end
    end
  end

  ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk       (clk),
    .we_i      (mem_we),
    .waddr_i   (mem_waddr),
    .wdata_i   (mem_wdata),
    .a_re_i    (a_re),
    .a_raddr_i (bus.a_addr),
    .a_rdata_o (arr_a_rdata),
    .b_re_i    (b_re),
    .b_raddr_i (bus.b_addr),
    .b_rdata_o (arr_b_rdata)
  );

  // The array has no reset, so read data is forced to zero until the first read after reset.
  assign bus.a_rdata  = a_seen_q ? arr_a_rdata : '0;
  assign bus.b_rdata  = b_seen_q ? arr_b_rdata : '0;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.ready    = (state_q == RAM_READY);
endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Self-checking bench for dual_port_ram_ctrl against a word-array reference model.
module tb_dual_port_ram_ctrl;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dual_port_ram_ctrl_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  dual_port_ram_ctrl #(
    .DATA_W         (8),
    .ADDR_W         (8),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] model [256];
  int         clear_left;
  logic       exp_arv, exp_brv;
  logic [7:0] exp_ard, exp_brd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".ready"},    32'(bus.ready),    32'(clear_left == 0));
    chk({ctx, ".a_rvalid"}, 32'(bus.a_rvalid), 32'(exp_arv));
    chk({ctx, ".b_rvalid"}, 32'(bus.b_rvalid), 32'(exp_brv));
    chk({ctx, ".a_rdata"},  32'(bus.a_rdata),  32'(exp_ard));
    chk({ctx, ".b_rdata"},  32'(bus.b_rdata),  32'(exp_brd));
  endtask

  task automatic zero_model();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  // One clock: drive inputs, advance the model, then compare just after the edge.
  task automatic step(input logic acs, input logic awe, input logic [7:0] aaddr,
                      input logic [7:0] awdata, input logic bcs, input logic [7:0] baddr,
                      input logic clr, input string ctx);
    bus.a_cs = acs; bus.a_we = awe; bus.a_addr = aaddr; bus.a_wdata = awdata;
    bus.b_cs = bcs; bus.b_addr = baddr; bus.clr_req = clr;
    if (clear_left > 0) begin
      exp_arv = 1'b0;
      exp_brv = 1'b0;
      clear_left--;
    end else begin
      exp_arv = acs && !awe;
      exp_brv = bcs;
      if (exp_arv) exp_ard = model[aaddr];
      if (exp_brv) exp_brd = model[baddr];
      if (acs && awe) model[aaddr] = awdata;
      if (clr) begin
        clear_left = 256;
        zero_model();
      end
    end
    @(posedge clk);
    #1;
    check_outputs(ctx);
  endtask

  task automatic idle(input string ctx);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, ctx);
  endtask

  task automatic apply_reset();
    bus.a_cs = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_cs = 1'b0; bus.b_addr = '0; bus.clr_req = 1'b0;
    rst_n = 1'b0;
    exp_arv = 1'b0; exp_brv = 1'b0; exp_ard = 8'h00; exp_brd = 8'h00;
    clear_left = 256;
    zero_model();
    #1;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset_hold");
    rst_n = 1'b1;
  endtask

  task automatic clear_with_noise(input string ctx);
    for (int i = 0; i < 256; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom),
           8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 1)), ctx);
  endtask

  initial begin
    // Test 1: fill with 0xAA, reset, expect a full 256-cycle clear then zeros.
    apply_reset();
    clear_with_noise("init_clear");
    for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 8'(i), 8'hAA, 1'b0, 8'h00, 1'b0, "fill_aa");
    step(1'b1, 1'b0, 8'h33, 8'h00, 1'b1, 8'hC4, 1'b0, "aa_readback");
    apply_reset();
    clear_with_noise("t1_clear");
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "t1_rd00");
    step(1'b1, 1'b0, 8'h7F, 8'h00, 1'b0, 8'h00, 1'b0, "t1_rd7f");
    step(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, "t1_rdff");

    // Test 2: write then read back with latency 1.
    step(1'b1, 1'b1, 8'h05, 8'h12, 1'b0, 8'h00, 1'b0, "t2_wr");
    step(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 8'h00, 1'b0, "t2_rd");
    idle("t2_idle");

    // Test 3: collision gives B the old word, next read the new one.
    step(1'b1, 1'b1, 8'h10, 8'h33, 1'b0, 8'h00, 1'b0, "t3_pre");
    step(1'b1, 1'b1, 8'h10, 8'h44, 1'b1, 8'h10, 1'b0, "t3_coll");
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h10, 1'b0, "t3_after");

    // Random traffic on a small address window to provoke collisions.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
           8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 1'b0, "rand");

    // Test 4: clear on request; the same-cycle read is still serviced.
    step(1'b1, 1'b1, 8'h20, 8'hFF, 1'b0, 8'h00, 1'b0, "t4_wr");
    step(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'h20, 1'b1, "t4_req");
    clear_with_noise("t4_clear");
    step(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 8'h20, 1'b0, "t4_rd");

    // Test 5: reset in the middle of a clear.
    step(1'b1, 1'b1, 8'h31, 8'h5A, 1'b0, 8'h00, 1'b0, "t5_wr");
    step(1'b1, 1'b0, 8'h31, 8'h00, 1'b1, 8'h31, 1'b0, "t5_rd");
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, "t5_req");
    for (int i = 0; i < 100; i++) idle("t5_clear");
    apply_reset();
    clear_with_noise("t5_reclear");

    // Test 6: fill with random words, stream B reads over the whole array.
    for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 8'(i), 8'($urandom), 1'b0, 8'h00, 1'b0, "t6_fill");
    for (int i = 0; i < 256; i++)
      step(1'($urandom_range(0, 1)), 1'b0, 8'($urandom), 8'h00, 1'b1, 8'(i), 1'b0, "t6_stream");
    idle("t6_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
